dacframe_rx: RTL
================

# dacframe_rx

Serial frame receiver for the 24-bit DAC write protocol: 4-bit opcode in bits 23:20, 12-bit sample in bits 19:8, 8 don't-care bits, MSB first, framed by active-low SYNC. It sits on the loopback/monitor side of the QPSK DAC link. It oversamples SCLK, SYNC and DIN in the system clock domain, deserialises each frame, checks opcode and length, and presents the recovered sample with a one-cycle valid strobe, so the transmit path can be verified in-system.

## Interface
- FRAME_BITS, 24: bits per frame.
- DATA_LSB, 8: bit position of the sample LSB within the frame.
- DATA_WIDTH, 12: sample width.
- EXP_OPCODE, 3: expected opcode (Write DAC Register).
- SYNC_STAGES, 2: synchroniser depth for SCLKin, SYNCin and DIN (minimum 2).

Ports:
- CLKin, input, 1: system clock. Must be at least 4× the SCLKin frequency.
- RSTin, input, 1: reset. Synchronous and active-high.
- SCLKin, input, 1: serial clock, asynchronous to CLKin.
- SYNCin, input, 1: frame select, active low, asynchronous.
- DIN, input, 1: serial data, asynchronous.
- dataout, output, DATA_WIDTH: last accepted sample.
- opcode, output, 4: opcode of the last complete frame.
- valid, output, 1: one-cycle pulse when dataout/opcode update on a good frame.
- frame_err, output, 1: one-cycle pulse on a bad frame (short, long, or wrong opcode).
- busy, output, 1: high while a frame is being received.

## Operation
- **Synchronisers:** all three serial inputs pass through SYNC_STAGES flops, then one edge-detect register.
  - SCLK fall = synchronised SCLK was 1 last cycle and is 0 now.
  - SYNC rise and SYNC fall are detected the same way.
- **Sampling:** DIN is sampled on the SCLK falling edge. The transmitter changes data on the rising edge.
- **States:**
  - ARM: reached after reset. Waits until SYNC is seen high, then → IDLE.
  - IDLE: on SYNC fall → SHIFT. Clears the 24-bit shift register and the 5-bit bit counter.
  - SHIFT: on each SCLK fall, shifts DIN into the shift register LSB and increments the counter.
    - The counter saturates at FRAME_BITS+1, which marks a long frame.
    - On SYNC rise → CHECK.
  - CHECK: one cycle, then → IDLE.
    - Good frame (counter == FRAME_BITS and shift[23:20] == EXP_OPCODE): load dataout = shift[DATA_LSB+DATA_WIDTH-1:DATA_LSB] and opcode = shift[23:20]; pulse valid.
    - Otherwise: pulse frame_err. dataout is unchanged.
    - If counter == FRAME_BITS but the opcode is wrong, opcode still updates.
- **Simultaneous events:** if SYNC rise and SCLK fall occur in the same cycle, SYNC wins and that bit is not counted.
- **busy:** high in SHIFT and CHECK.
- **SYNC fall in CHECK:** ignored. A frame must start from IDLE, so a back-to-back frame needs at least one CLKin cycle of SYNC high after CHECK.
- **Reset mid-frame:** the partial frame is discarded and no pulse is issued. The block goes to ARM, so a frame already in progress when RSTin is released is never half-captured.

## Timing
- Reset values: dataout=0, opcode=0, valid=0, frame_err=0, busy=0, state=ARM, shift register=0, counter=0.
- Input latency: SYNC_STAGES + 1 CLKin cycles from a pin transition to its edge detection.
- valid/frame_err go high on the 2nd CLKin edge after the SYNC rise is detected, which is SYNC_STAGES+2 edges after SYNCin is first sampled high. They stay high exactly 1 cycle.
- dataout and opcode change in the same cycle that valid goes high, and hold until the next good frame.
- Minimum SCLKin high and low time: 2 CLKin periods. Edges closer together than that may be lost; that is outside spec.

## Structure
- Shared package `dac_proto_pkg`:
  - Opcode constants (OP_WRITE_DAC = 4'd3).
  - FRAME_BITS, DATA_LSB, DATA_WIDTH.
  - Receiver state enum (ARM, IDLE, SHIFT, CHECK).
  - The same constants are used by the transmitter.
- One sub-module: `sync_edge`, instantiated three times. Parameterised depth; outputs the synchronised level plus rise and fall pulses.

## Test plan
- Reset, then one frame of opcode 3, data 12'hA5C, SCLK = CLKin/8 → one valid pulse, dataout=12'hA5C, opcode=4'd3, frame_err never high.
- Frame with opcode 4'd2, data 12'h123 → frame_err pulse, no valid, dataout keeps the prior 12'hA5C, opcode=4'd2.
- SYNC raised after 17 bits → frame_err, no valid, busy low within SYNC_STAGES+3 cycles.
- 26 SCLK falls inside one SYNC window → frame_err; the next good frame with 12'hFFF → valid, dataout=12'hFFF.
- RSTin asserted at bit 10, released with SYNC still low, frame completes → no pulse at all. The following full frame with 12'h001 → valid, dataout=12'h001.
- Two back-to-back good frames 12'h000 then 12'h800 with 2 SCLK periods of SYNC high between them → two valid pulses, dataout ends at 12'h800.

Source files
------------

// File: rtl/dac_proto_pkg.sv
// Shared definitions for the 24-bit DAC write protocol.
// The transmitter and the loopback receiver both use these constants.
package dac_proto_pkg;

  // Opcode field of the serial frame
  localparam int          OPCODE_WIDTH = 4;
  localparam logic [3:0]  OP_WRITE_DAC = 4'd3;

  // Frame layout: opcode in the top nibble, sample below it, then padding
  localparam int FRAME_BITS = 24;
  localparam int DATA_LSB   = 8;
  localparam int DATA_WIDTH = 12;

  // Receiver control states
  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK
  } rx_state_t;

endpackage

// File: rtl/dacframe_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a single
// edge-detect register. level, rise and fall are mutually time-aligned.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              level_reg;
  logic              rise_reg;
  logic              fall_reg;

  // Synchroniser chain plus edge detection. Resetting to 0 means a pin that
  // is high out of reset shows up as a rise, never as a spurious fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[STAGES-2:0], d};
      level_reg <= sync_reg[STAGES-1];
      rise_reg  <= sync_reg[STAGES-1] & ~level_reg;
      fall_reg  <= ~sync_reg[STAGES-1] & level_reg;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/dacframe_rx.sv
// Oversampling receiver for the DAC write frame: synchronises SCLK/SYNC/DIN,
// deserialises MSB first, checks length and opcode, and reports the sample.
module dacframe_rx #(
  parameter int         FRAME_BITS  = dac_proto_pkg::FRAME_BITS,
  parameter int         DATA_LSB    = dac_proto_pkg::DATA_LSB,
  parameter int         DATA_WIDTH  = dac_proto_pkg::DATA_WIDTH,
  parameter logic [3:0] EXP_OPCODE  = dac_proto_pkg::OP_WRITE_DAC,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  CLKin,
  input  logic                  RSTin,
  input  logic                  SCLKin,
  input  logic                  SYNCin,
  input  logic                  DIN,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic [3:0]            opcode,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  import dac_proto_pkg::*;

  // Counter must hold FRAME_BITS+1 (the "too long" marker)
  localparam int             CW       = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0]  CNT_LONG = CW'(FRAME_BITS + 1);
  localparam int             OP_MSB   = FRAME_BITS - 1;

  // Pin index inside the synchroniser vector
  localparam int PIN_SCLK = 0;
  localparam int PIN_SYNC = 1;
  localparam int PIN_DIN  = 2;

  logic [2:0] pin_vec;
  logic [2:0] lvl;
  logic [2:0] rise;
  logic [2:0] fall;

  assign pin_vec = {DIN, SYNCin, SCLKin};

  // Identical synchroniser per pin keeps DIN aligned with the SCLK edge
  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    sync_edge #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (CLKin),
      .rst  (RSTin),
      .d    (pin_vec[gi]),
      .level(lvl[gi]),
      .rise (rise[gi]),
      .fall (fall[gi])
    );
  end

  logic sclk_fall;
  logic sync_rise;
  logic sync_fall;
  logic sync_level;
  logic din_level;
  logic unused_edges;

  assign sclk_fall    = fall[PIN_SCLK];
  assign sync_rise    = rise[PIN_SYNC];
  assign sync_fall    = fall[PIN_SYNC];
  assign sync_level   = lvl[PIN_SYNC];
  assign din_level    = lvl[PIN_DIN];
  assign unused_edges = ^{rise[PIN_SCLK], lvl[PIN_SCLK], rise[PIN_DIN], fall[PIN_DIN]};

  rx_state_t             state_reg,   state_next;
  logic [FRAME_BITS-1:0] shift_reg,   shift_next;
  logic [CW-1:0]         cnt_reg,     cnt_next;
  logic [DATA_WIDTH-1:0] dataout_reg, dataout_next;
  logic [3:0]            opcode_reg,  opcode_next;
  logic                  valid_reg,   valid_next;
  logic                  err_reg,     err_next;

  // State and datapath registers
  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      state_reg   <= ST_ARM;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      dataout_reg <= '0;
      opcode_reg  <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      dataout_reg <= dataout_next;
      opcode_reg  <= opcode_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  // Frame sequencing, deserialisation and the end-of-frame verdict
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    dataout_next = dataout_reg;
    opcode_next  = opcode_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;

    unique case (state_reg)
      ST_ARM: begin
        // Only start listening once the line is idle, so a frame already in
        // flight at reset release is skipped entirely.
        if (sync_level) begin
          state_next = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (sync_fall) begin
          state_next = ST_SHIFT;
          shift_next = '0;
          cnt_next   = '0;
        end
      end

      ST_SHIFT: begin
        // End of frame takes priority over a coincident SCLK edge
        if (sync_rise) begin
          state_next = ST_CHECK;
        end else if (sclk_fall) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], din_level};
          if (cnt_reg != CNT_LONG) begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end

      ST_CHECK: begin
        state_next = ST_IDLE;
        if (cnt_reg == CNT_FULL) begin
          // A complete frame always reports its opcode, good or not
          opcode_next = shift_reg[OP_MSB -: 4];
          if (shift_reg[OP_MSB -: 4] == EXP_OPCODE) begin
            dataout_next = shift_reg[DATA_LSB +: DATA_WIDTH];
            valid_next   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          err_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_ARM;
      end
    endcase
  end

  assign dataout   = dataout_reg;
  assign opcode    = opcode_reg;
  assign valid     = valid_reg;
  assign frame_err = err_reg;
  assign busy      = (state_reg == ST_SHIFT) || (state_reg == ST_CHECK);

endmodule
